data_mem_responder: RTL and testbench

Responder side of the CPU data-memory interface: accepts one load/store request per handshake from the core's memory stage, holds it for a programmable number of wait states, then commits the write or returns read data with a one-cycle acknowledge. It sits between the CPU datapath and a word-organised on-chip storage array. It gives the multi-cycle CPU a realistic memory with back-pressure in place of a zero-latency combinational data memory.

---
 rtl/dmem_resp_pkg.sv | 23 ++
 rtl/mem_resp_array.sv | 51 +++++
 rtl/data_mem_responder.sv | 182 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dmem_resp_pkg
// Summary  : Shared types and constants for the data-memory responder:
//            FSM state encoding, wait-counter width and word/byte geometry.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_resp_pkg;

    localparam int LATENCY_MAX    = 15;
    localparam int CNT_W          = 4;
    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_resp_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_array
// Summary  : DEPTH x 32-bit word store with a synchronous byte-enable write
//            port and a registered read port. The read register can be forced
//            to zero so an erroring load returns a clean value. Storage
//            contents are not reset; only the read register is.
// Revision : 1.0 - initial release
// ============================================================================
module mem_resp_array
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [WORD_W-1:0]         wr_data,
    input  logic [BYTES_PER_WORD-1:0] wr_be,
    input  logic                      rd_en,
    input  logic                      rd_zero,
    input  logic [IDX_W-1:0]          rd_idx,
    output logic [WORD_W-1:0]         rd_data
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Byte-lane write: only lanes with their enable set are updated
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES_PER_WORD; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][b*BYTE_W +: BYTE_W] <= wr_data[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Registered read port; holds its value between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_zero ? '0 : mem[rd_idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Summary  : CPU data-memory responder. Accepts one load/store per handshake,
//            holds it for LATENCY wait states, then commits the write or
//            returns read data together with a one-cycle ack.
// Config   : DMEM_RESP_ERR_EN - when defined, misaligned or out-of-range
//            addresses complete with err_o=1, never modify the array and
//            return zero on loads. When undefined, err_o is 0, the low two
//            address bits are ignored and the word index wraps modulo DEPTH.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import dmem_resp_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        ready_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LATENCY);

    state_t                      state;
    state_t                      state_nxt;
    logic [CNT_W-1:0]            cnt;
    logic                        accept;
    logic                        commit;

    logic                        lat_we;
    logic [WORD_W-1:0]           lat_addr;
    logic [WORD_W-1:0]           lat_wdata;
    logic [BYTES_PER_WORD-1:0]   lat_be;

    logic                        cmd_we;
    logic [WORD_W-1:0]           cmd_addr;
    logic [WORD_W-1:0]           cmd_wdata;
    logic [BYTES_PER_WORD-1:0]   cmd_be;
    logic                        cmd_err;
    logic [IDX_W-1:0]            cmd_idx;

    logic                        ready_q;
    logic                        ack_q;
    logic                        err_q;

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; commit marks the edge that enters RESP
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (req_i) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // With zero wait states the commit happens on the accept edge itself,
    // so the live inputs are used; otherwise the latched request is used
    always_comb begin
        if (state == IDLE) begin
            cmd_we    = we_i;
            cmd_addr  = addr_i;
            cmd_wdata = wdata_i;
            cmd_be    = be_i;
        end else begin
            cmd_we    = lat_we;
            cmd_addr  = lat_addr;
            cmd_wdata = lat_wdata;
            cmd_be    = lat_be;
        end
    end

    assign cmd_idx = cmd_addr[IDX_W+1:2];

`ifdef DMEM_RESP_ERR_EN
    assign cmd_err = (cmd_addr[1:0] != 2'b00) || (cmd_addr[WORD_W-1:IDX_W+2] != '0);
`else
    // Address bits outside the word index are intentionally ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cmd_addr[WORD_W-1:IDX_W+2], cmd_addr[1:0]};
    assign cmd_err          = 1'b0;
`endif

    // Request latch and wait-state counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else if (accept) begin
            cnt       <= LAT_INIT;
            lat_we    <= we_i;
            lat_addr  <= addr_i;
            lat_wdata <= wdata_i;
            lat_be    <= be_i;
        end else if (state == WAIT) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Registered handshake outputs and error flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_q <= 1'b1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= (state_nxt == IDLE);
            ack_q   <= (state_nxt == RESP);
            if (commit) begin
                err_q <= cmd_err;
            end else if (state == RESP) begin
                err_q <= 1'b0;
            end
        end
    end

    mem_resp_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_en   (commit & cmd_we & ~cmd_err),
        .wr_idx  (cmd_idx),
        .wr_data (cmd_wdata),
        .wr_be   (cmd_be),
        .rd_en   (commit & ~cmd_we),
        .rd_zero (cmd_err),
        .rd_idx  (cmd_idx),
        .rd_data (rdata_o)
    );

    assign ready_o = ready_q;
    assign ack_o   = ack_q;
    assign err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Summary  : Self-checking bench for data_mem_responder. Two instances run
//            side by side (LATENCY=2 and LATENCY=0) against a word-array
//            reference model. Honours DMEM_RESP_ERR_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int DEPTH = 128;
    localparam int LAT [2] = '{2, 0};

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  be    [2];
    logic        ready [2];
    logic        ack   [2];
    logic [31:0] rdata [2];
    logic        err   [2];

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [2][DEPTH];
    logic [31:0] model_rd  [2];

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut_l2 (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req[0]),
        .we_i    (we[0]),
        .addr_i  (addr[0]),
        .wdata_i (wdata[0]),
        .be_i    (be[0]),
        .ready_o (ready[0]),
        .ack_o   (ack[0]),
        .rdata_o (rdata[0]),
        .err_o   (err[0])
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut_l0 (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req[1]),
        .we_i    (we[1]),
        .addr_i  (addr[1]),
        .wdata_i (wdata[1]),
        .be_i    (be[1]),
        .ready_o (ready[1]),
        .ack_o   (ack[1]),
        .rdata_o (rdata[1]),
        .err_o   (err[1])
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic model_err(input logic [31:0] a);
`ifdef DMEM_RESP_ERR_EN
        return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_apply(input int s, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] b,
                               output logic [31:0] exp_rd, output logic exp_er);
        int idx;
        exp_er = model_err(a);
        idx    = int'((a / 4) % DEPTH);
        if (w) begin
            if (!exp_er) begin
                for (int n = 0; n < 4; n++) begin
                    if (b[n]) model_mem[s][idx][8*n +: 8] = d[8*n +: 8];
                end
            end
        end else begin
            model_rd[s] = exp_er ? 32'h0 : model_mem[s][idx];
        end
        exp_rd = model_rd[s];
    endtask

    // One complete transaction; reports latency in cycles after the accept
    // edge, cycles with ready low, and the ack-cycle data/error
    task automatic xact(input int s, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output int lat, output int lowcnt,
                        output logic [31:0] rd, output logic er, output logic rdy_after);
        @(negedge clk);
        we[s] = w; addr[s] = a; wdata[s] = d; be[s] = b; req[s] = 1'b1;
        lat = -1; lowcnt = 0; rd = '0; er = 1'b0; rdy_after = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) req[s] = 1'b0;
            if (!ready[s]) lowcnt++;
            if (ack[s]) begin
                lat = k; rd = rdata[s]; er = err[s];
                break;
            end
        end
        req[s] = 1'b0;
        @(negedge clk);
        rdy_after = ready[s];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req[s] = 0; we[s] = 0; addr[s] = 0; wdata[s] = 0; be[s] = 0;
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (ready[s] !== 1'b1 || ack[s] !== 1'b0 || rdata[s] !== 32'h0 || err[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state inst%0d: ready=%b ack=%b rdata=%h err=%b expected 1 0 0 0",
                         s, ready[s], ack[s], rdata[s], err[s]);
            end
            model_rd[s] = 32'h0;
        end
        rst = 1'b0;
    endtask

    task automatic test_fill;
        int lat, low; logic [31:0] rd, erd; logic er, eer, ra;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < DEPTH; i++) begin
                logic [31:0] d;
                d = $urandom;
                model_apply(s, 1'b1, 32'(i * 4), d, 4'hF, erd, eer);
                xact(s, 1'b1, 32'(i * 4), d, 4'hF, lat, low, rd, er, ra);
                checks++;
                if (lat != LAT[s] + 1 || er !== 1'b0) begin
                    errors++;
                    $display("FAIL fill inst%0d word %0d: lat=%0d err=%b expected lat=%0d err=0",
                             s, i, lat, er, LAT[s] + 1);
                end
            end
        end
    endtask

    task automatic test_store_load;
        int lat, low; logic [31:0] rd, erd; logic er, eer, ra;
        model_apply(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer);
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, low, rd, er, ra);
        checks++;
        if (lat != 3 || low != 3 || ra !== 1'b1) begin
            errors++;
            $display("FAIL store_timing: lat=%0d ready_low=%0d ready_after=%b expected 3 3 1", lat, low, ra);
        end
        checks++;
        if (rd !== erd) begin
            errors++;
            $display("FAIL store_rdata_hold: rdata=%h expected %h", rd, erd);
        end
        model_apply(0, 1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, low, rd, er, ra);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 3) begin
            errors++;
            $display("FAIL load_after_store: rdata=%h err=%b lat=%0d expected deadbeef 0 3", rd, er, lat);
        end
    endtask

    task automatic test_byte_enable;
        int lat, low; logic [31:0] rd, erd; logic er, eer, ra;
        model_apply(0, 1'b1, 32'h20, 32'h11223344, 4'hF, erd, eer);
        xact(0, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, low, rd, er, ra);
        model_apply(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, erd, eer);
        xact(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, low, rd, er, ra);
        model_apply(0, 1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, lat, low, rd, er, ra);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL byte_enable_merge: rdata=%h expected 11bb33dd", rd);
        end
        model_apply(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, erd, eer);
        xact(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, lat, low, rd, er, ra);
        checks++;
        if (lat != 3 || rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL be_zero_store: lat=%0d rdata=%h expected 3 11bb33dd", lat, rd);
        end
        model_apply(0, 1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, lat, low, rd, er, ra);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL be_zero_noop: rdata=%h expected 11bb33dd", rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, exp_rd; logic eer; int acks;
        acks = 0;
        @(negedge clk);
        a = 32'($urandom_range(DEPTH - 1)) << 2;
        model_apply(1, 1'b0, a, 32'h0, 4'h0, exp_rd, eer);
        we[1] = 1'b0; addr[1] = a; be[1] = 4'($urandom); req[1] = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k % 2 == 1) begin
                checks++;
                if (ack[1] !== 1'b1 || ready[1] !== 1'b0 || rdata[1] !== exp_rd) begin
                    errors++;
                    $display("FAIL b2b_ack cycle %0d: ack=%b ready=%b rdata=%h expected 1 0 %h",
                             k, ack[1], ready[1], rdata[1], exp_rd);
                end
                if (ack[1] === 1'b1) acks++;
                if (k < 15) begin
                    a = 32'($urandom_range(DEPTH - 1)) << 2;
                    model_apply(1, 1'b0, a, 32'h0, 4'h0, exp_rd, eer);
                    addr[1] = a;
                end else begin
                    req[1] = 1'b0;
                end
            end else begin
                checks++;
                if (ack[1] !== 1'b0 || ready[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_gap cycle %0d: ack=%b ready=%b expected 0 1", k, ack[1], ready[1]);
                end
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (ack[1] === 1'b1) acks++;
        end
        checks++;
        if (acks != 8) begin
            errors++;
            $display("FAIL b2b_ack_count: acks=%0d expected 8", acks);
        end
    endtask

    task automatic test_reset_in_wait;
        int lat, low; logic [31:0] rd, erd, old; logic er, eer, ra; int stray;
        old = model_mem[0][2];
        @(negedge clk);
        we[0] = 1'b1; addr[0] = 32'h8; wdata[0] = ~old; be[0] = 4'hF; req[0] = 1'b1;
        @(negedge clk);
        req[0] = 1'b0;
        checks++;
        if (ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL wait_ready: ready=%b expected 0", ready[0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ready[0] !== 1'b1 || ack[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_wait: ready=%b ack=%b expected 1 0", ready[0], ack[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        model_rd[0] = 32'h0;
        model_rd[1] = 32'h0;
        stray = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack[0] === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL reset_dropped_ack: acks=%0d expected 0", stray);
        end
        model_apply(0, 1'b0, 32'h8, 32'h0, 4'h0, erd, eer);
        xact(0, 1'b0, 32'h8, 32'h0, 4'h0, lat, low, rd, er, ra);
        checks++;
        if (rd !== old) begin
            errors++;
            $display("FAIL reset_no_write: rdata=%h expected %h", rd, old);
        end
    endtask

    task automatic test_addr_config;
        int lat, low; logic [31:0] rd, erd; logic er, eer, ra;
`ifdef DMEM_RESP_ERR_EN
        logic [31:0] w0;
        w0 = model_mem[0][0];
        model_apply(0, 1'b1, 32'h202, 32'hCAFEF00D, 4'hF, erd, eer);
        xact(0, 1'b1, 32'h202, 32'hCAFEF00D, 4'hF, lat, low, rd, er, ra);
        checks++;
        if (er !== 1'b1 || lat != 3) begin
            errors++;
            $display("FAIL err_store: err=%b lat=%0d expected 1 3", er, lat);
        end
        model_apply(0, 1'b0, 32'h200, 32'h0, 4'h0, erd, eer);
        xact(0, 1'b0, 32'h200, 32'h0, 4'h0, lat, low, rd, er, ra);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL err_load: err=%b rdata=%h expected 1 00000000", er, rd);
        end
        model_apply(0, 1'b0, 32'h0, 32'h0, 4'h0, erd, eer);
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, lat, low, rd, er, ra);
        checks++;
        if (er !== 1'b0 || rd !== w0) begin
            errors++;
            $display("FAIL err_store_no_change: err=%b rdata=%h expected 0 %h", er, rd, w0);
        end
`else
        model_apply(0, 1'b1, 32'h200, 32'hCAFEF00D, 4'hF, erd, eer);
        xact(0, 1'b1, 32'h200, 32'hCAFEF00D, 4'hF, lat, low, rd, er, ra);
        checks++;
        if (er !== 1'b0) begin
            errors++;
            $display("FAIL wrap_store_err: err=%b expected 0", er);
        end
        model_apply(0, 1'b0, 32'h0, 32'h0, 4'h0, erd, eer);
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, lat, low, rd, er, ra);
        checks++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
            errors++;
            $display("FAIL wrap_word0: rdata=%h err=%b expected cafef00d 0", rd, er);
        end
`endif
    endtask

    task automatic test_random;
        int lat, low; logic [31:0] rd, erd, a, d; logic er, eer, ra, w; logic [3:0] b;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 60; i++) begin
                w = 1'($urandom);
                d = $urandom;
                b = 4'($urandom);
                if ($urandom_range(3) == 0) a = $urandom;
                else a = 32'($urandom_range(DEPTH - 1)) << 2;
                model_apply(s, w, a, d, b, erd, eer);
                xact(s, w, a, d, b, lat, low, rd, er, ra);
                checks++;
                if (lat != LAT[s] + 1 || low != LAT[s] + 1 || ra !== 1'b1 ||
                    rd !== erd || er !== eer) begin
                    errors++;
                    $display("FAIL random inst%0d #%0d we=%b addr=%h: lat=%0d low=%0d rdy=%b rdata=%h err=%b expected lat=%0d low=%0d rdy=1 rdata=%h err=%b",
                             s, i, w, a, lat, low, ra, rd, er, LAT[s] + 1, LAT[s] + 1, erd, eer);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_store_load();
        test_byte_enable();
        test_back_to_back();
        test_reset_in_wait();
        test_addr_config();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
